// File: rtl/ts_pkt_deframer.sv
// rtl/ts_pkt_deframer.sv - serial TS oversampler, MSB-first byte assembler and sync-byte packet framer
// Optional saturating packet/error counters: define TS_DEFRAMER_STATS_EN
`timescale 1ns/1ps
module ts_pkt_deframer #(
    parameter int         PKT_LEN    = 188,
    parameter logic [7:0] SYNC_BYTE  = 8'h47,
    parameter int         LOCK_CNT   = 3,
    parameter int         UNLOCK_CNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ts_clk,
    input  logic        ts_valid,
    input  logic        ts_sync,
    input  logic        ts_d0,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic        locked,
    output logic        sync_err
`ifdef TS_DEFRAMER_STATS_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
`endif
);
    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
    localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCK} state_t;

    // synchronizer bit order: {ts_clk, ts_valid, ts_sync, ts_d0}
    logic [3:0] in_s1_q, in_s1_d, in_s2_q, in_s2_d;
    logic       tsclk_s3_q, tsclk_s3_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       byte_rdy_q, byte_rdy_d;

    state_t     state_q, state_d;
    logic [7:0] byte_idx_q, byte_idx_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic       locked_q, locked_d, err_q, err_d;

    logic       strobe, s_valid, s_sync, s_d0, is_sync;
    logic [7:0] next_idx, next_match, next_miss;

    assign strobe     = in_s2_q[3] & ~tsclk_s3_q;
    assign s_valid    = in_s2_q[2];
    assign s_sync     = in_s2_q[1];
    assign s_d0       = in_s2_q[0];
    assign is_sync    = (shreg_q == SYNC_BYTE);
    assign next_idx   = (byte_idx_q == LAST_IDX) ? 8'd0 : byte_idx_q + 8'd1;
    assign next_match = match_cnt_q + 8'd1;
    assign next_miss  = miss_cnt_q + 8'd1;

    always_comb begin
        in_s1_d    = {ts_clk, ts_valid, ts_sync, ts_d0};
        in_s2_d    = in_s1_q;
        tsclk_s3_d = in_s2_q[3];
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_rdy_d = 1'b0;
        if (strobe) begin
            if (!s_valid) begin
                bit_cnt_d = 4'd0;
            end else if (s_sync) begin
                shreg_d   = {7'd0, s_d0};
                bit_cnt_d = 4'd1;
            end else begin
                shreg_d = {shreg_q[6:0], s_d0};
                if (bit_cnt_q == 4'd7) begin
                    bit_cnt_d  = 4'd0;
                    byte_rdy_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
        end
    end

    // shreg_q still holds the completed byte on the clk after byte_rdy_q is set
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        err_d       = 1'b0;
        if (byte_rdy_q) begin
            case (state_q)
                ST_HUNT: begin
                    if (is_sync) begin
                        byte_idx_d  = 8'd1;
                        match_cnt_d = 8'd1;
                        if (LOCK_N == 8'd1) begin
                            state_d    = ST_LOCK;
                            miss_cnt_d = 8'd0;
                            valid_d    = 1'b1;
                            sop_d      = 1'b1;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (byte_idx_q != 8'd0) begin
                        byte_idx_d = next_idx;
                    end else if (is_sync) begin
                        byte_idx_d  = 8'd1;
                        match_cnt_d = next_match;
                        if (next_match == LOCK_N) begin
                            state_d    = ST_LOCK;
                            miss_cnt_d = 8'd0;
                            valid_d    = 1'b1;
                            sop_d      = 1'b1;
                        end
                    end else begin
                        state_d     = ST_HUNT;
                        match_cnt_d = 8'd0;
                        byte_idx_d  = 8'd0;
                    end
                end
                ST_LOCK: begin
                    valid_d    = 1'b1;
                    sop_d      = (byte_idx_q == 8'd0);
                    eop_d      = (byte_idx_q == LAST_IDX);
                    byte_idx_d = next_idx;
                    if (byte_idx_q == 8'd0) begin
                        if (is_sync) begin
                            miss_cnt_d = 8'd0;
                        end else if (next_miss == UNLOCK_N) begin
                            state_d     = ST_HUNT;
                            valid_d     = 1'b0;
                            sop_d       = 1'b0;
                            byte_idx_d  = 8'd0;
                            miss_cnt_d  = 8'd0;
                            match_cnt_d = 8'd0;
                        end else begin
                            miss_cnt_d = next_miss;
                            err_d      = 1'b1;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
            if (valid_d) begin
                data_d = shreg_q;
            end
        end
        locked_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_s1_q     <= 4'd0;
            in_s2_q     <= 4'd0;
            tsclk_s3_q  <= 1'b0;
            shreg_q     <= 8'd0;
            bit_cnt_q   <= 4'd0;
            byte_rdy_q  <= 1'b0;
            state_q     <= ST_HUNT;
            byte_idx_q  <= 8'd0;
            match_cnt_q <= 8'd0;
            miss_cnt_q  <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            in_s1_q     <= in_s1_d;
            in_s2_q     <= in_s2_d;
            tsclk_s3_q  <= tsclk_s3_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_rdy_q  <= byte_rdy_d;
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign byte_data  = data_q;
    assign byte_valid = valid_q;
    assign pkt_sop    = sop_q;
    assign pkt_eop    = eop_q;
    assign locked     = locked_q;
    assign sync_err   = err_q;

`ifdef TS_DEFRAMER_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (valid_d && eop_d && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
`endif
endmodule
